// File: rtl/scarv_ccx_mmio_master.sv
// Generic synchronous FIFO: registered storage, no pass-through, count output.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: the caller must not push when count==DEPTH or pop when count==0.
module scarv_ccx_mmio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     f_clk,
  input  logic                     g_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count   = wr_ptr - rd_ptr;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge f_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// CCX memif initiator: queued commands become single-outstanding bus requests.
// Latency: command accepted in N -> mmio_req in N+1 -> rsp_valid in N+3 (zero-wait grant).
// Backpressure: cmd_ready drops when the command FIFO is full; requests stall without response credit.
module scarv_ccx_mmio_master #(
  parameter int CMD_DEPTH      = 2,
  parameter int RSP_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        f_clk,
  input  logic        g_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wen,
  input  logic [3:0]  cmd_strb,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        mmio_req,
  input  logic        mmio_gnt,
  output logic        mmio_wen,
  output logic [3:0]  mmio_strb,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_error,
  output logic        busy
);
  typedef struct packed {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } rsp_t;

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int WCW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  cmd_t              cmd_in, cmd_head;
  rsp_t              rsp_in, rsp_head;
  logic [CMD_CW-1:0] cmd_count;
  logic [RSP_CW-1:0] rsp_count;
  logic [RSP_CW:0]   occupancy;
  logic [WCW-1:0]    wait_cnt;
  logic              cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic              head_vld, head_aligned, credit;
  logic              grant, misal_pop, timeout_pop, wait_last;
  logic              inflight, pend_bus, pend_wen, pend_to;

  assign cmd_in   = '{wen: cmd_wen, strb: cmd_strb, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !g_reset && (cmd_count != CMD_CW'(CMD_DEPTH));
  assign cmd_push  = cmd_valid && cmd_ready;

  scarv_ccx_mmio_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .f_clk    (f_clk),
    .g_reset  (g_reset),
    .push     (cmd_push),
    .push_dat (cmd_in),
    .pop      (cmd_pop),
    .pop_dat  (cmd_head),
    .count    (cmd_count)
  );

  // Responses already queued plus the one being captured this cycle must leave room.
  assign rsp_valid = !g_reset && (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign occupancy = {1'b0, rsp_count} + {{RSP_CW{1'b0}}, inflight} - {{RSP_CW{1'b0}}, rsp_pop};
  assign credit    = occupancy < (RSP_CW+1)'(RSP_DEPTH);

  assign head_vld     = !g_reset && (cmd_count != '0);
  assign head_aligned = (cmd_head.addr[1:0] == 2'b00);
  assign mmio_req     = head_vld && head_aligned && credit;
  assign mmio_wen     = cmd_head.wen;
  assign mmio_strb    = cmd_head.strb;
  assign mmio_addr    = cmd_head.addr;
  assign mmio_wdata   = cmd_head.wdata;

  assign wait_last   = (TIMEOUT_CYCLES != 0) && (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
  assign grant       = mmio_req && mmio_gnt;
  assign misal_pop   = head_vld && !head_aligned && credit;
  assign timeout_pop = mmio_req && !mmio_gnt && wait_last;
  assign cmd_pop     = grant || misal_pop || timeout_pop;

  always_ff @(posedge f_clk) begin
    if (g_reset) begin
      inflight <= 1'b0;
      pend_bus <= 1'b0;
      pend_wen <= 1'b0;
      pend_to  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      inflight <= cmd_pop;
      if (cmd_pop) begin
        pend_bus <= grant;
        pend_wen <= cmd_head.wen;
        pend_to  <= timeout_pop;
      end
      if (cmd_pop)
        wait_cnt <= '0;
      else if (mmio_req && (TIMEOUT_CYCLES != 0))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Locally generated errors (misalignment, timeout) never carry bus data.
  always_comb begin
    rsp_in = '0;
    if (pend_bus) begin
      rsp_in.error = mmio_error;
      rsp_in.rdata = (pend_wen || mmio_error) ? 32'h0 : mmio_rdata;
    end else begin
      rsp_in.error   = 1'b1;
      rsp_in.timeout = pend_to;
    end
  end

  assign rsp_push = inflight;

  scarv_ccx_mmio_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .f_clk    (f_clk),
    .g_reset  (g_reset),
    .push     (rsp_push),
    .push_dat (rsp_in),
    .pop      (rsp_pop),
    .pop_dat  (rsp_head),
    .count    (rsp_count)
  );

  assign rsp_rdata   = rsp_head.rdata;
  assign rsp_error   = rsp_head.error;
  assign rsp_timeout = rsp_head.timeout;
  assign busy        = !g_reset && ((cmd_count != '0) || inflight || (rsp_count != '0));
endmodule

// File: tb/tb_scarv_ccx_mmio_master.sv
// Bench for scarv_ccx_mmio_master: directed scenarios plus random traffic against a
// transaction-level model (expected response per command, memory image, stall plan).
module tb_scarv_ccx_mmio_master;
  localparam int TO = 16;

  logic        f_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wen = 1'b0;
  logic [3:0]  cmd_strb = '0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error, rsp_timeout;
  logic        mmio_req, mmio_gnt = 1'b0, mmio_wen;
  logic [3:0]  mmio_strb;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [31:0] mmio_rdata = '0;
  logic        mmio_error = 1'b0;
  logic        busy;

  always #5 f_clk = ~f_clk;

  scarv_ccx_mmio_master #(.CMD_DEPTH(2), .RSP_DEPTH(2), .TIMEOUT_CYCLES(TO)) dut (
    .f_clk(f_clk), .g_reset(g_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wen(cmd_wen), .cmd_strb(cmd_strb),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .mmio_req(mmio_req), .mmio_gnt(mmio_gnt), .mmio_wen(mmio_wen), .mmio_strb(mmio_strb),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .mmio_error(mmio_error), .busy(busy)
  );

  typedef struct {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  int          vectors = 0, miscompares = 0;
  exp_t        exp_q[$];
  bus_t        bus_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] bus_mem   [16];
  int          force_stall = -1;
  bit          in_txn = 0, pend_vld = 0;
  int          req_cnt = 0;
  bus_t        cur;
  logic [31:0] pend_rdata;
  logic        pend_err;
  logic        s_req, s_cmd_rdy, s_rsp_vld, s_busy;
  int          grants = 0, req_cycles = 0, req_run = 0, req_run_max = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return a[31:6] == 26'h40;
  endfunction

  // Expected outcome of each accepted command, decided in command order.
  task automatic model_accept();
    bus_t c;
    exp_t e;
    c.wen = cmd_wen; c.strb = cmd_strb; c.addr = cmd_addr; c.wdata = cmd_wdata;
    if (force_stall >= 0) c.stall = force_stall;
    else case ($urandom_range(0, 9))
      0: c.stall = 1;
      1: c.stall = 3;
      2: c.stall = 15;
      3: c.stall = 16;
      default: c.stall = 0;
    endcase
    e = '0;
    if (c.addr[1:0] != 2'b00) begin
      e.err = 1'b1;
    end else begin
      bus_q.push_back(c);
      if (c.stall >= TO) begin
        e.err = 1'b1; e.to = 1'b1;
      end else if (!mapped(c.addr)) begin
        e.err = 1'b1;
      end else if (c.wen) begin
        model_mem[c.addr[5:2]] = merge(model_mem[c.addr[5:2]], c.wdata, c.strb);
      end else begin
        e.rdata = model_mem[c.addr[5:2]];
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock: sample just after the falling edge, act as scoreboard and bus responder.
  task automatic tick();
    exp_t e;
    #1;
    s_req = mmio_req; s_cmd_rdy = cmd_ready; s_rsp_vld = rsp_valid; s_busy = busy;
    req_run = mmio_req ? req_run + 1 : 0;
    if (req_run > req_run_max) req_run_max = req_run;
    if (cmd_valid && cmd_ready) model_accept();
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 72'(rsp_valid), 72'(0));
      else begin
        e = exp_q.pop_front();
        chk("rsp", 72'({rsp_rdata, rsp_error, rsp_timeout}), 72'(e));
      end
    end
    mmio_gnt = 1'b0;
    if (in_txn && !mmio_req) begin
      chk("req_hold", 72'(mmio_req), 72'(1));
      in_txn = 0;
    end
    if (mmio_req) begin
      req_cycles++;
      if (!in_txn) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 72'(mmio_req), 72'(0));
          cur.wen = mmio_wen; cur.strb = mmio_strb; cur.addr = mmio_addr;
          cur.wdata = mmio_wdata; cur.stall = 0;
        end else begin
          cur = bus_q.pop_front();
          chk("bus_cmd", 72'({mmio_wen, mmio_strb, mmio_addr, mmio_wdata}),
              72'({cur.wen, cur.strb, cur.addr, cur.wdata}));
        end
        in_txn = 1; req_cnt = 0;
      end else begin
        chk("bus_hold", 72'({mmio_wen, mmio_strb, mmio_addr, mmio_wdata}),
            72'({cur.wen, cur.strb, cur.addr, cur.wdata}));
      end
      if (req_cnt == cur.stall) begin
        mmio_gnt = 1'b1; grants++; in_txn = 0; pend_vld = 1;
        if (cur.wen && mapped(cur.addr))
          bus_mem[cur.addr[5:2]] = merge(bus_mem[cur.addr[5:2]], cur.wdata, cur.strb);
        pend_rdata = (!cur.wen && mapped(cur.addr)) ? bus_mem[cur.addr[5:2]] : $urandom;
        pend_err   = !mapped(cur.addr);
      end else begin
        req_cnt++;
        if (req_cnt == TO) in_txn = 0;
      end
    end
    @(negedge f_clk);
    mmio_gnt = 1'b0;
    if (pend_vld) begin
      mmio_rdata = pend_rdata; mmio_error = pend_err; pend_vld = 0;
    end else begin
      mmio_rdata = $urandom; mmio_error = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb);
    bit done;
    done = 0;
    cmd_valid = 1'b1; cmd_wen = wen; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = s_cmd_rdy;
    end
    cmd_valid = 1'b0;
    if (!done) chk("send_accept", 72'(s_cmd_rdy), 72'(1));
  endtask

  task automatic do_reset(input int cycles);
    g_reset = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1; mmio_gnt = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk("reset_outs", 72'({cmd_ready, mmio_req, rsp_valid, busy}), 72'(0));
      @(negedge f_clk);
    end
    cmd_valid = 1'b0;
    exp_q.delete(); bus_q.delete();
    in_txn = 0; pend_vld = 0; req_run = 0;
    model_mem = bus_mem;
    g_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'h1234_5678 + i * 32'h0101_0101;
      bus_mem[i]   = model_mem[i];
    end
    @(negedge f_clk);
    do_reset(2);

    // single read: accepted in N, request N+1, response visible N+3
    force_stall = 0; rsp_ready = 1'b1;
    send(1'b0, 32'h0000_1000, 32'h0, 4'hf);
    tick(); chk("sr_req_n1", 72'(s_req), 72'(1));
    tick(); chk("sr_rsp_n2", 72'(s_rsp_vld), 72'(0));
    tick(); chk("sr_rsp_n3", 72'(s_rsp_vld), 72'(1));
    tick(); chk("sr_busy_after", 72'(s_busy), 72'(0));

    // back-to-back writes
    req_run_max = 0;
    send(1'b1, 32'h0000_1008, 32'hA1A2_A3A4, 4'hf);
    send(1'b1, 32'h0000_100C, 32'hB1B2_B3B4, 4'h3);
    send(1'b1, 32'h0000_1000, 32'hC1C2_C3C4, 4'hc);
    send(1'b1, 32'h0000_1004, 32'hD1D2_D3D4, 4'h5);
    idle(6);
    chk("b2b_req_run", 72'(req_run_max), 72'(4));
    chk("b2b_drain", 72'(exp_q.size()), 72'(0));

    // response backpressure limits the bus to two transactions
    rsp_ready = 1'b0; grants = 0;
    send(1'b0, 32'h0000_1008, 32'h0, 4'hf);
    send(1'b0, 32'h0000_100C, 32'h0, 4'hf);
    send(1'b0, 32'h0000_1000, 32'h0, 4'hf);
    send(1'b0, 32'h0000_1004, 32'h0, 4'hf);
    idle(6);
    chk("bp_grants", 72'(grants), 72'(2));
    chk("bp_req_low", 72'(s_req), 72'(0));
    chk("bp_cmd_full", 72'(s_cmd_rdy), 72'(0));
    rsp_ready = 1'b1;
    idle(10);
    chk("bp_grants_all", 72'(grants), 72'(4));
    chk("bp_drain", 72'(exp_q.size()), 72'(0));

    // grant timeout, then a grant in the last allowed cycle
    force_stall = 16; req_cycles = 0;
    send(1'b0, 32'h0000_1010, 32'h0, 4'hf);
    idle(25);
    chk("to_req_cycles", 72'(req_cycles), 72'(16));
    force_stall = 15; req_cycles = 0;
    send(1'b1, 32'h0000_1010, 32'h5566_7788, 4'hf);
    idle(25);
    chk("late_gnt_req_cycles", 72'(req_cycles), 72'(16));
    chk("to_drain", 72'(exp_q.size()), 72'(0));

    // bus error and misaligned address
    force_stall = 0;
    send(1'b0, 32'h0000_1040, 32'h0, 4'hf);
    idle(5);
    req_cycles = 0;
    send(1'b0, 32'h0000_1002, 32'h0, 4'hf);
    idle(5);
    chk("misal_no_req", 72'(req_cycles), 72'(0));
    chk("err_drain", 72'(exp_q.size()), 72'(0));

    // reset the cycle after a grant
    grants = 0;
    send(1'b0, 32'h0000_1014, 32'h0, 4'hf);
    tick();
    chk("rst_pre_grant", 72'(grants), 72'(1));
    do_reset(1);
    idle(5);
    chk("rst_busy", 72'(s_busy), 72'(0));
    send(1'b0, 32'h0000_1018, 32'h0, 4'hf);
    idle(6);
    chk("rst_next_drain", 72'(exp_q.size()), 72'(0));

    // random traffic
    force_stall = -1;
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_wen   = 1'($urandom_range(0, 1));
      cmd_strb  = 4'($urandom_range(0, 15));
      cmd_wdata = $urandom;
      cmd_addr  = 32'h0000_1000 + {25'h0, 5'($urandom_range(0, 31)), 2'b00};
      if ($urandom_range(0, 7) == 0) cmd_addr[1:0] = 2'($urandom_range(1, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || in_txn); i++) tick();
    chk("rand_drain", 72'(exp_q.size()), 72'(0));
    tick();
    chk("rand_busy", 72'(s_busy), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
